// File: rtl/qspis_wb_arb.sv
// Two-master Wishbone arbiter: cycle-framed round-robin grant of the shared
// system slave port, response routing to the owner, and a watchdog that
// aborts unacknowledged strobes with an err pulse to the owner.
module qspis_wb_arb #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_CNT = 200
) (
  input  logic        sys_clk,
  input  logic        rst,
  // master 0: QSPI-slave bridge
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1: UART debug bridge
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave port
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [31:0] s_adr_o,
  output logic        s_we_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  // status
  output logic        gnt_o,
  output logic        gnt_vld_o,
  output logic        tmo_flag_o,
  input  logic        tmo_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CNT - 1);

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic own_cyc;
  logic own_stb;
  logic req_any;
  logic pick;
  logic stalled;
  logic expire;

  // Owner view, arbitration pick and watchdog expiry
  always_comb begin
    own_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;
    own_stb = gnt_q ? m1_stb_i : m0_stb_i;
    req_any = m0_cyc_i | m1_cyc_i;
    pick    = (m0_cyc_i & m1_cyc_i) ? ~last_q : m1_cyc_i;
    stalled = (state_q == ST_GRANT) & own_cyc & own_stb & ~s_ack_i & ~s_err_i;
    expire  = stalled & (tmo_cnt_q == TMO_LAST);
  end

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, round-robin history, watchdog counter and sticky flag
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Next-state: grant on request, hold for the whole cycle, abort on expiry
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    tmo_cnt_d  = '0;
    tmo_flag_d = tmo_flag_q;
    if (tmo_clr_i) begin
      tmo_flag_d = 1'b0;
    end
    if (expire) begin
      tmo_flag_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_GRANT;
          gnt_d   = pick;
          last_d  = pick;
        end
      end
      ST_GRANT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_ABORT;
        end else if (stalled) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: slave-side mux and response routing gated by state
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_adr_o    = m0_adr_i;
    s_we_o     = m0_we_i;
    s_dat_o    = m0_dat_i;
    s_sel_o    = m0_sel_i;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m0_dat_o   = s_dat_i;
    m1_dat_o   = s_dat_i;
    gnt_o      = gnt_q;
    gnt_vld_o  = (state_q == ST_GRANT);
    tmo_flag_o = tmo_flag_q;
    if (state_q == ST_GRANT) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      if (gnt_q) begin
        s_adr_o  = m1_adr_i;
        s_we_o   = m1_we_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | expire;
      end else begin
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | expire;
      end
    end
  end

endmodule

// File: doc/qspis_wb_arb.md
Name: qspis_wb_arb

Overview:
Two-master Wishbone arbiter in front of the shared system Wishbone slave port. Master 0 is the QSPI-slave bridge WB master; master 1 is the second host-debug WB master (UART bridge). Grants whole cycles (cyc-framed) round-robin, routes ack/err/data back to the owner, and aborts hung accesses with a watchdog that returns err to the owner.

Parameters:
TMO_W, 8, width of watchdog counter
TMO_CNT, 200, cycles of unacknowledged s_stb before abort (1 .. 2^TMO_W-1)

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous active-high reset
m0_cyc_i  in  1  master0 (QSPI bridge) cycle
m0_stb_i  in  1  master0 strobe
m0_adr_i  in  32  master0 address
m0_we_i  in  1  master0 write
m0_dat_i  in  32  master0 write data
m0_sel_i  in  4  master0 byte enable
m0_dat_o  out  32  read data to master0
m0_ack_o  out  1  ack to master0
m0_err_o  out  1  err to master0
m1_cyc_i, m1_stb_i, m1_adr_i, m1_we_i, m1_dat_i, m1_sel_i, m1_dat_o, m1_ack_o, m1_err_o  same as m0_*, master1 (UART bridge)
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_adr_o  out  32  slave address
s_we_o  out  1  slave write
s_dat_o  out  32  slave write data
s_sel_o  out  4  slave byte enable
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
gnt_o  out  1  current owner index (0/1)
gnt_vld_o  out  1  grant active (state GRANT)
tmo_flag_o  out  1  sticky: watchdog abort occurred
tmo_clr_i  in  1  clears tmo_flag_o

Behaviour:
- Reset (async, immediate): state IDLE, gnt_o=0, gnt_vld_o=0, last=1 (m0 wins first tie), tmo_cnt=0, tmo_flag_o=0; all s_* and m*_ack/err outputs 0 (combinational gating from state).
- States: IDLE, GRANT, ABORT.
- IDLE: if any mX_cyc_i=1 -> GRANT next edge, gnt_o = requester; both requesting -> gnt_o = ~last. last updated to the new owner on entry to GRANT. No request -> stay.
- GRANT: s_cyc/stb/adr/we/dat/sel = owner's inputs (combinational mux); owner mX_ack_o=s_ack_i, mX_err_o=s_err_i; non-owner ack/err=0. s_dat_i broadcast to both mX_dat_o always.
- GRANT held while owner cyc=1 (multiple stb beats allowed). Owner cyc=0 -> IDLE next edge; one dead cycle before any new grant (arbitrate in IDLE).
- Non-owner requests ignored until owner releases; no preemption.
- Watchdog: tmo_cnt increments each GRANT cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0; cleared on ack, err, stb low, or leaving GRANT. When tmo_cnt==TMO_CNT-1 and still no ack/err: that cycle drive owner mX_err_o=1 (one cycle), set tmo_flag_o, go ABORT.
- ack/err in same cycle as watchdog expiry: ack/err forwarded, no abort.
- ABORT: s_cyc_o=s_stb_o=0, no ack/err to anyone; stay until owner cyc=0, then IDLE. Late s_ack_i in ABORT is dropped.
- tmo_flag_o: set on abort, cleared by tmo_clr_i; set wins if same cycle.
- IDLE: s_cyc_o=s_stb_o=0; s_adr/dat/sel/we driven from master0 inputs (don't-care).
- gnt_vld_o=1 only in GRANT.
- Mid-transaction reset: outputs drop same instant; after release, first grant again to m0 on tie.

Test Plan:
- m0 single read adr 0x3000_0004, slave acks after 3 cycles data 0xA5A5_1234 -> grant 1 cycle after cyc, m0_dat_o=0xA5A5_1234 with m0_ack_o, m1_ack_o=0, IDLE one cycle after cyc drop.
- m0 and m1 assert cyc same cycle, both hold 3 back-to-back transfers -> order m0, m1, m0, m1 with one idle cycle between grants; gnt_o toggles.
- m1 holds cyc over 4 stb beats (burst writes sel=0xF) while m0 requests -> m0 stalled until m1 cyc low, s_* never mixes sources.
- TMO_CNT=200, slave never acks m0 write -> m0_err_o pulse exactly on 200th stb cycle, s_cyc_o low next cycle, tmo_flag_o=1 until tmo_clr_i; ack injected on cycle 200 -> ack passed, no err, flag stays 0.
- Slave s_err_i on m1 read -> m1_err_o=1 same cycle, m0_err_o=0, watchdog cleared.
- rst asserted mid-GRANT with stb high -> s_cyc_o/gnt_vld_o 0 immediately, tmo_flag_o 0; after release both request -> m0 granted first.
